scan_chain_ctrl: RTL and testbench
==================================

Name: scan_chain_ctrl

Overview:
- Tester-side driver for a chain of scan flip-flops with set/reset; this is the opposite end of the flops' SE/SI scan port.
- Shifts a parallel pattern serially into the chain, issues one capture cycle, then unloads the chain tail serially into a parallel response register.
- Sits between the test-pattern source and the scan chain. The chain shares CK with this block.

Parameters:
- CHAIN_LEN, 8, number of flops in the chain (>=1).
- CNT_W, 4, bit counter width; must satisfy 2^CNT_W > CHAIN_LEN.

Ports:
- CK  input  1  clock, rising-edge.
- RST  input  1  asynchronous, active-high reset.
- START  input  1  request a load/capture/unload sequence; sampled only in IDLE.
- PAT_IN  input  CHAIN_LEN  pattern to load; element k of the chain receives PAT_IN[k].
- SO  input  1  serial output from chain tail (element CHAIN_LEN-1).
- SE  output  1  scan enable to every chain flop; 1 = shift, 0 = capture.
- SI  output  1  serial input to chain head (element 0).
- BUSY  output  1  high in every state except IDLE.
- DONE  output  1  one-cycle pulse; RESP_OUT valid while DONE is high.
- RESP_OUT  output  CHAIN_LEN  captured response; RESP_OUT[k] = element k after the capture edge.

Behaviour:
- Clock and reset: one clock, CK. Reset is asynchronous and active-high on RST; the polarity and synchronicity are fixed.
- Reset values: state = IDLE, SE = 0, SI = 0, BUSY = 0, DONE = 0, RESP_OUT = 0, counter = 0, pattern shadow register = 0.
- State machine: IDLE -> SHIFT -> CAPTURE -> UNLOAD -> DONE_ST -> IDLE.
- IDLE:
  - SE = 0, SI = 0.
  - If START = 1 at an edge: latch PAT_IN into the shadow register, set counter = 0, go to SHIFT.
- SHIFT:
  - SE = 1, SI = shadow[CHAIN_LEN-1-counter]; MSB first.
  - On each edge, counter increments.
  - On the edge where counter = CHAIN_LEN-1, clear counter and go to CAPTURE.
- CAPTURE:
  - SE = 0, SI = 0, for exactly one cycle.
  - The chain captures functional D on this edge. Next state is UNLOAD, counter = 0.
- UNLOAD:
  - SE = 1, SI = 0.
  - On each edge, sample SO before the chain shifts: resp <= {resp[CHAIN_LEN-2:0], SO}. The first sample lands in bit CHAIN_LEN-1.
  - After CHAIN_LEN samples, load RESP_OUT from resp and go to DONE_ST.
- DONE_ST:
  - DONE = 1, SE = 0, BUSY = 1, for one cycle; then IDLE.
  - RESP_OUT holds until the next DONE or reset.
- Latency: if START is accepted at edge 0, the SHIFT edges are 1..CHAIN_LEN, the capture edge is CHAIN_LEN+1, the unload edges are CHAIN_LEN+2..2*CHAIN_LEN+1, and DONE is high in the cycle after edge 2*CHAIN_LEN+1.
- START in any state other than IDLE is ignored; no queueing.
- START held high continuously starts a new sequence in the first IDLE cycle after DONE_ST. Back-to-back period is 2*CHAIN_LEN+3 cycles.
- PAT_IN changes after acceptance have no effect.
- CHAIN_LEN = 1: SHIFT and UNLOAD last one cycle each.
- RST mid-sequence: immediate return to IDLE with SE = 0 and RESP_OUT = 0, no DONE pulse. The chain contents are undefined afterwards.
- Outputs SE, SI, BUSY and DONE are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: SCAN_CMP_EN.
- Defined:
  - Adds input EXP_IN [CHAIN_LEN] (latched at START acceptance) and output MISMATCH [1].
  - MISMATCH = |(RESP_OUT ^ exp_shadow), registered and valid with DONE, held until the next DONE. Reset value 0.
- Undefined: neither port exists, and there is no compare logic.

Test Plan:
- Bench setup: CHAIN_LEN = 8. The bench instantiates an 8-flop behavioural chain whose functional D = ~Q.
- PAT_IN = 8'hA5, START pulse -> SI during SHIFT = 1,0,1,0,0,1,0,1; SE = 1 for 8 cycles, then 0 for 1 cycle, then 1 for 8 cycles; DONE high 17 cycles after the START edge; RESP_OUT = 8'h5A.
- PAT_IN = 8'h00, then 8'hFF back-to-back with START held high -> RESP_OUT = 8'hFF, then 8'h00; second DONE exactly 19 cycles after the first.
- START pulsed again in the cycle after acceptance (PAT_IN = 8'h3C during the sequence, 8'h11 at the second pulse) -> ignored; RESP_OUT = 8'hC3; exactly one DONE.
- RST asserted asynchronously mid-SHIFT (counter = 3) -> SE, SI, BUSY, DONE and RESP_OUT read 0 before the next edge; a fresh START with 8'h81 completes normally with RESP_OUT = 8'h7E.
- With SCAN_CMP_EN: PAT = 8'hA5, EXP = 8'h5A -> MISMATCH = 0; EXP = 8'h5B -> MISMATCH = 1 with DONE.

Source files
------------

// File: rtl/scan_chain_ctrl_if.sv
// ============================================================================
//  Module      : scan_chain_ctrl_if
//  Description : Signal bundle between the scan chain controller, the
//                pattern source and the scan chain it drives.
//                Optional compare ports exist only when SCAN_CMP_EN is
//                defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface scan_chain_ctrl_if #(
  parameter int CHAIN_LEN = 8
);

  logic                 start;
  logic [CHAIN_LEN-1:0] pat_in;
  logic                 so;
  logic                 se;
  logic                 si;
  logic                 busy;
  logic                 done;
  logic [CHAIN_LEN-1:0] resp_out;
`ifdef SCAN_CMP_EN
  logic [CHAIN_LEN-1:0] exp_in;
  logic                 mismatch;
`endif

`ifdef SCAN_CMP_EN
  // Tester environment side: pattern source plus the chain tail.
  modport master (
    output start, pat_in, so, exp_in,
    input  se, si, busy, done, resp_out, mismatch
  );

  // Controller side.
  modport slave (
    input  start, pat_in, so, exp_in,
    output se, si, busy, done, resp_out, mismatch
  );
`else
  // Tester environment side: pattern source plus the chain tail.
  modport master (
    output start, pat_in, so,
    input  se, si, busy, done, resp_out
  );

  // Controller side.
  modport slave (
    input  start, pat_in, so,
    output se, si, busy, done, resp_out
  );
`endif

endinterface : scan_chain_ctrl_if

`default_nettype wire

// File: rtl/scan_chain_ctrl.sv
// ============================================================================
//  Module      : scan_chain_ctrl
//  Description : Tester-side scan chain driver. Shifts a parallel pattern
//                into the chain MSB first, issues one capture cycle, then
//                unloads the chain tail into a parallel response register.
//                Optional feature macro SCAN_CMP_EN adds an expected-response
//                input and a registered mismatch flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scan_chain_ctrl #(
  parameter int CHAIN_LEN = 8,
  parameter int CNT_W     = 4
) (
  input  wire logic         clk,
  input  wire logic         rst,
  scan_chain_ctrl_if.slave  bus
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_SHIFT   = 3'd1;
  localparam logic [2:0] c_CAPTURE = 3'd2;
  localparam logic [2:0] c_UNLOAD  = 3'd3;
  localparam logic [2:0] c_DONE_ST = 3'd4;

  // Terminal count for both the shift and the unload phase.
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(CHAIN_LEN - 1);

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic [2:0]           r_state;
  logic [2:0]           w_state_next;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_next;
  logic [CHAIN_LEN-1:0] r_shadow;
  logic [CHAIN_LEN-1:0] r_resp;
  logic [CHAIN_LEN-1:0] w_resp_next;
  logic [CHAIN_LEN-1:0] r_resp_out;
  logic                 r_se;
  logic                 r_si;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_last;
  logic                 w_accept;
  logic                 w_shift_adv;
  logic                 w_unload;
  logic                 w_unload_last;

  assign w_last        = (r_cnt == c_LAST);
  assign w_accept      = (r_state == c_IDLE) && bus.start;
  assign w_shift_adv   = (r_state == c_SHIFT) && !w_last;
  assign w_unload      = (r_state == c_UNLOAD);
  assign w_unload_last = w_unload && w_last;

  // --------------------------------------------------------------------------
  // Response shift path. SO is sampled before the chain moves, entering at
  // bit 0, so the first sample ends up in bit CHAIN_LEN-1.
  // --------------------------------------------------------------------------
  generate
    if (CHAIN_LEN == 1) begin : g_resp_single
      assign w_resp_next = bus.so;
    end else begin : g_resp_multi
      assign w_resp_next = {r_resp[CHAIN_LEN-2:0], bus.so};
    end
  endgenerate

  // Next-state and counter decode for the load/capture/unload sequence.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      c_IDLE: begin
        if (bus.start) begin
          w_state_next = c_SHIFT;
          w_cnt_next   = '0;
        end
      end
      c_SHIFT: begin
        if (w_last) begin
          w_state_next = c_CAPTURE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next   = r_cnt + 1'b1;
        end
      end
      c_CAPTURE: begin
        w_state_next = c_UNLOAD;
        w_cnt_next   = '0;
      end
      c_UNLOAD: begin
        if (w_last) begin
          w_state_next = c_DONE_ST;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next   = r_cnt + 1'b1;
        end
      end
      c_DONE_ST: begin
        w_state_next = c_IDLE;
        w_cnt_next   = '0;
      end
      default: begin
        w_state_next = c_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // State and bit counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Pattern shadow: latched at acceptance, then shifted left so that its MSB
  // always holds the next bit to present on SI.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow <= '0;
    end else if (w_accept) begin
      r_shadow <= bus.pat_in << 1;
    end else if (w_shift_adv) begin
      r_shadow <= r_shadow << 1;
    end
  end

  // Registered scan-side and status outputs, decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_se   <= 1'b0;
      r_si   <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_se   <= (w_state_next == c_SHIFT) || (w_state_next == c_UNLOAD);
      r_busy <= (w_state_next != c_IDLE);
      r_done <= (w_state_next == c_DONE_ST);
      if (w_accept) begin
        r_si <= bus.pat_in[CHAIN_LEN-1];
      end else if (w_shift_adv) begin
        r_si <= r_shadow[CHAIN_LEN-1];
      end else begin
        r_si <= 1'b0;
      end
    end
  end

  // Response accumulation during unload, published on the final sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_resp     <= '0;
      r_resp_out <= '0;
    end else if (w_unload) begin
      r_resp <= w_resp_next;
      if (w_last) begin
        r_resp_out <= w_resp_next;
      end
    end
  end

`ifdef SCAN_CMP_EN
  logic [CHAIN_LEN-1:0] r_exp_shadow;
  logic                 r_mismatch;

  // Expected response latched alongside the pattern; flag updated with DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_exp_shadow <= '0;
      r_mismatch   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_exp_shadow <= bus.exp_in;
      end
      if (w_unload_last) begin
        r_mismatch <= |(w_resp_next ^ r_exp_shadow);
      end
    end
  end

  assign bus.mismatch = r_mismatch;
`endif

  // --------------------------------------------------------------------------
  // Output mapping
  // --------------------------------------------------------------------------
  assign bus.se       = r_se;
  assign bus.si       = r_si;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.resp_out = r_resp_out;

endmodule : scan_chain_ctrl

`default_nettype wire

// File: tb/tb_scan_chain_ctrl.sv
// ============================================================================
//  Module      : tb_scan_chain_ctrl
//  Description : Self-checking bench for scan_chain_ctrl driving an 8-flop
//                behavioural chain whose functional D is ~Q. Compare checks
//                are included when SCAN_CMP_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scan_chain_ctrl;

  localparam int CL = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  scan_chain_ctrl_if #(.CHAIN_LEN(CL)) bus ();

  scan_chain_ctrl #(
    .CHAIN_LEN (CL),
    .CNT_W     (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural scan chain: shift on SE=1, capture ~Q on SE=0.
  logic [CL-1:0] chain = '0;
  always @(posedge clk) begin
    if (bus.se) chain <= {chain[CL-2:0], bus.si};
    else        chain <= ~chain;
  end
  assign bus.so = chain[CL-1];

  int n_checks   = 0;
  int n_err      = 0;
  int cyc        = 0;
  int done_seen  = 0;
  int done_cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.done === 1'b1) done_seen <= done_seen + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected {se, si, busy, done} in the cycle after edge e, where edge 0
  // is the START acceptance edge.
  function automatic logic [3:0] exp_ctl(input int e, input logic [CL-1:0] pat);
    if (e < CL)            return {1'b1, pat[CL-1-e], 1'b1, 1'b0};
    else if (e == CL)      return 4'b0010;
    else if (e <= 2*CL)    return 4'b1010;
    else if (e == 2*CL+1)  return 4'b0011;
    else                   return 4'b0000;
  endfunction

  function automatic logic [3:0] ctl_now();
    return {bus.se, bus.si, bus.busy, bus.done};
  endfunction

  // Caller has driven START/PAT_IN during an idle cycle. Runs through the
  // whole sequence and returns at the negedge of the first idle cycle.
  task automatic run_seq(input logic [CL-1:0] pat, input logic [CL-1:0] resp,
                         input logic mism, input bit again, input bit hold,
                         input logic [CL-1:0] next_pat);
    @(posedge clk);
    #1;
    if (again) begin
      bus.start  = 1'b1;
      bus.pat_in = 8'h11;
    end else if (hold) begin
      bus.pat_in = next_pat;
    end else begin
      bus.start  = 1'b0;
      bus.pat_in = CL'($urandom);
    end
    for (int e = 0; e <= 2*CL+2; e++) begin
      @(negedge clk);
      chk($sformatf("ctl_e%0d", e), 32'(ctl_now()), 32'(exp_ctl(e, pat)));
      if (e == 2*CL+1) begin
        done_cyc = cyc;
        chk("resp_out", 32'(bus.resp_out), 32'(resp));
`ifdef SCAN_CMP_EN
        chk("mismatch", 32'(bus.mismatch), 32'(mism));
`else
        if (mism === 1'bx) $display("note: unknown compare expectation");
`endif
      end
      if (again && e == 0) begin
        @(posedge clk);
        #1;
        bus.start = 1'b0;
      end
    end
  endtask

  typedef struct {
    logic [CL-1:0] pat;
    logic [CL-1:0] exp_cmp;
    bit            again;
    logic [CL-1:0] resp;
    logic          mism;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int t1;
    int d0;
    logic [CL-1:0] p;
    logic [CL-1:0] x;

    vecs[0] = '{pat: 8'hA5, exp_cmp: 8'h5A, again: 1'b0, resp: 8'h5A, mism: 1'b0};
    vecs[1] = '{pat: 8'hA5, exp_cmp: 8'h5B, again: 1'b0, resp: 8'h5A, mism: 1'b1};
    vecs[2] = '{pat: 8'h3C, exp_cmp: 8'hC3, again: 1'b1, resp: 8'hC3, mism: 1'b0};
    vecs[3] = '{pat: 8'h00, exp_cmp: 8'h00, again: 1'b0, resp: 8'hFF, mism: 1'b1};
    vecs[4] = '{pat: 8'h0F, exp_cmp: 8'hF0, again: 1'b0, resp: 8'hF0, mism: 1'b0};

    bus.start  = 1'b0;
    bus.pat_in = '0;
`ifdef SCAN_CMP_EN
    bus.exp_in = '0;
`endif

    // Reset state.
    #1 rst = 1'b1;
    #1;
    chk("reset_ctl", 32'(ctl_now()), 32'h0);
    chk("reset_resp", 32'(bus.resp_out), 32'h0);
`ifdef SCAN_CMP_EN
    chk("reset_mism", 32'(bus.mismatch), 32'h0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ctl", 32'(ctl_now()), 32'h0);

    // Table-driven vectors.
    for (int i = 0; i < 5; i++) begin
      bus.start  = 1'b1;
      bus.pat_in = vecs[i].pat;
`ifdef SCAN_CMP_EN
      bus.exp_in = vecs[i].exp_cmp;
`endif
      d0 = done_seen;
      run_seq(vecs[i].pat, vecs[i].resp, vecs[i].mism, vecs[i].again, 1'b0, '0);
      chk($sformatf("vec%0d_one_done", i), 32'(done_seen - d0), 32'd1);
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        chk($sformatf("vec%0d_idle", i), 32'(ctl_now()), 32'h0);
      end
    end

    // Asynchronous reset mid-shift (counter = 3), then a clean restart.
    bus.start  = 1'b1;
    bus.pat_in = 8'hA5;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_ctl", 32'(ctl_now()), 32'h0);
    chk("rst_mid_resp", 32'(bus.resp_out), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus.start  = 1'b1;
    bus.pat_in = 8'h81;
`ifdef SCAN_CMP_EN
    bus.exp_in = 8'h7E;
`endif
    run_seq(8'h81, 8'h7E, 1'b0, 1'b0, 1'b0, '0);

    // Back-to-back with START held high.
    bus.start  = 1'b1;
    bus.pat_in = 8'h00;
`ifdef SCAN_CMP_EN
    bus.exp_in = 8'hFF;
`endif
    run_seq(8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hFF);
    t1 = done_cyc;
`ifdef SCAN_CMP_EN
    bus.exp_in = 8'h00;
`endif
    run_seq(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, '0);
    chk("b2b_period", 32'(done_cyc - t1), 32'd19);

    // Randomized sequences against the reference: response = ~pattern.
    for (int n = 0; n < 20; n++) begin
      bus.start = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      p = CL'($urandom);
      x = (($urandom & 1) != 0) ? ~p : CL'($urandom);
      bus.start  = 1'b1;
      bus.pat_in = p;
`ifdef SCAN_CMP_EN
      bus.exp_in = x;
`endif
      run_seq(p, ~p, |((~p) ^ x), 1'b0, 1'b0, '0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule : tb_scan_chain_ctrl

`default_nettype wire
